// File: rtl/collision_arbiter.sv
// Multi-ball collision resolver: classifies ball overlaps with bat/brick pixels,
// handles per-ball once-per-frame arming with cooldown, and keeps brick-hit tallies.
module collision_arbiter #(
  parameter int NUM_BALLS       = 2,
  parameter int BALL_SIZE       = 14,
  parameter int EDGE            = 3,
  parameter int NUM_ZONES       = 7,
  parameter int ZONE_WIDTH      = 8,
  parameter int COOLDOWN_FRAMES = 0,
  parameter int BRICK_POINTS    = 10,
  parameter int SCORE_W         = 16,
  parameter int CNT_W           = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         startOfFrame,
  input  logic [NUM_BALLS-1:0]                         ballReq,
  input  logic [NUM_BALLS*11-1:0]                      ballOffsetX,
  input  logic [NUM_BALLS*11-1:0]                      ballOffsetY,
  input  logic                                         batReq,
  input  logic [10:0]                                  batOffsetX,
  input  logic                                         brikReq,
  output logic [NUM_BALLS*5-1:0]                       ballCollision,
  output logic [NUM_BALLS*$clog2(NUM_ZONES+1)-1:0]     batZone,
  output logic                                         brikCollision,
  output logic [CNT_W-1:0]                             frameBrickHits,
  output logic [SCORE_W-1:0]                           score
);

  localparam int ZONE_W = $clog2(NUM_ZONES + 1);
  localparam int COOL_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [10:0]        TOP_TH    = 11'(BALL_SIZE - EDGE);
  localparam logic [10:0]        BOT_TH    = 11'(EDGE);
  localparam logic [10:0]        MID_X     = 11'(BALL_SIZE / 2);
  localparam logic [COOL_W-1:0]  COOL_INIT = COOL_W'(COOLDOWN_FRAMES);
  localparam logic [SCORE_W:0]   POINTS    = (SCORE_W + 1)'(BRICK_POINTS);

  localparam logic [4:0] CODE_TOP    = 5'b10010;
  localparam logic [4:0] CODE_BOTTOM = 5'b10001;
  localparam logic [4:0] CODE_RIGHT  = 5'b11000;
  localparam logic [4:0] CODE_LEFT   = 5'b10100;

  // Priority compare against zone thresholds; the last zone absorbs the remainder.
  function automatic logic [ZONE_W-1:0] zone_of(input logic [10:0] x);
    logic [ZONE_W-1:0] z;
    z = ZONE_W'(1);
    for (int k = 1; k < NUM_ZONES; k++) begin
      if ({21'd0, x} >= 32'(k * ZONE_WIDTH)) z = ZONE_W'(k + 1);
    end
    return z;
  endfunction

  logic [NUM_BALLS-1:0]              armed_q, armed_d;
  logic [NUM_BALLS-1:0][COOL_W-1:0]  cool_q, cool_d;
  logic [NUM_BALLS-1:0]              armed_eff;
  logic [NUM_BALLS-1:0]              hit;

  logic [NUM_BALLS*5-1:0]            coll_q, coll_d;
  logic [NUM_BALLS*ZONE_W-1:0]       zone_q, zone_d;
  logic                              brik_q, brik_d;
  logic [CNT_W-1:0]                  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]                  frame_hits_q, frame_hits_d;
  logic [SCORE_W-1:0]                score_q, score_d;

  logic                              brick_evt;
  logic [CNT_W-1:0]                  frame_next;
  logic [SCORE_W:0]                  score_sum;

  // A hit always wins over the frame-start re-arm/countdown in the same cycle.
  always_comb begin
    armed_d   = armed_q;
    cool_d    = cool_q;
    armed_eff = '0;
    hit       = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      armed_eff[i] = armed_q[i] | (startOfFrame & (cool_q[i] == '0));
      hit[i]       = ballReq[i] & (batReq | brikReq) & armed_eff[i];
      if (startOfFrame) begin
        if (cool_q[i] == '0) armed_d[i] = 1'b1;
        else                 cool_d[i]  = cool_q[i] - COOL_W'(1);
      end
      if (hit[i]) begin
        armed_d[i] = 1'b0;
        cool_d[i]  = COOL_INIT;
      end
    end
  end

  always_comb begin
    logic [10:0] off_x;
    logic [10:0] off_y;
    coll_d = '0;
    zone_d = '0;
    off_x  = '0;
    off_y  = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      off_x = ballOffsetX[i*11 +: 11];
      off_y = ballOffsetY[i*11 +: 11];
      if (hit[i]) begin
        if (off_y >= TOP_TH) begin
          coll_d[i*5 +: 5] = CODE_TOP;
          if (batReq) zone_d[i*ZONE_W +: ZONE_W] = zone_of(batOffsetX);
        end else if (off_y < BOT_TH) begin
          coll_d[i*5 +: 5] = CODE_BOTTOM;
        end else if (off_x < MID_X) begin
          coll_d[i*5 +: 5] = CODE_RIGHT;
        end else begin
          coll_d[i*5 +: 5] = CODE_LEFT;
        end
      end
    end
  end

  // One brick event per cycle no matter how many balls touch bricks at once.
  always_comb begin
    brick_evt = (|hit) & brikReq;
    brik_d    = brick_evt;

    frame_next = frame_cnt_q;
    if (brick_evt && (frame_cnt_q != '1)) frame_next = frame_cnt_q + CNT_W'(1);

    frame_hits_d = frame_hits_q;
    frame_cnt_d  = frame_next;
    if (startOfFrame) begin
      frame_hits_d = frame_next;
      frame_cnt_d  = '0;
    end

    score_sum = {1'b0, score_q} + POINTS;
    score_d   = score_q;
    if (brick_evt) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q      <= '1;
      cool_q       <= '0;
      coll_q       <= '0;
      zone_q       <= '0;
      brik_q       <= 1'b0;
      frame_cnt_q  <= '0;
      frame_hits_q <= '0;
      score_q      <= '0;
    end else begin
      armed_q      <= armed_d;
      cool_q       <= cool_d;
      coll_q       <= coll_d;
      zone_q       <= zone_d;
      brik_q       <= brik_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_hits_q <= frame_hits_d;
      score_q      <= score_d;
    end
  end

  assign ballCollision  = coll_q;
  assign batZone        = zone_q;
  assign brikCollision  = brik_q;
  assign frameBrickHits = frame_hits_q;
  assign score          = score_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: four instances (default, cooldown 2,
// eight balls, eight balls with 2-bit frame counter) driven from one sequence.
module tb_collision_arbiter;

  localparam logic [4:0] TOP    = 5'b10010;
  localparam logic [4:0] BOTTOM = 5'b10001;
  localparam logic [4:0] RIGHT  = 5'b11000;
  localparam logic [4:0] LEFT   = 5'b10100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        startOfFrame;
  logic        batReq;
  logic        brikReq;
  logic [10:0] batOffsetX;
  logic [1:0]  reqA, reqB;
  logic [21:0] offX, offY;
  logic [7:0]  reqCD;
  logic [87:0] offX8, offY8;

  logic [9:0]  collA, collB;
  logic [5:0]  zoneA, zoneB;
  logic        brikA, brikB, brikC, brikD;
  logic [7:0]  hitsA, hitsB, hitsC;
  logic [1:0]  hitsD;
  logic [15:0] scoreA, scoreB, scoreC, scoreD;
  logic [39:0] collC, collD;
  logic [23:0] zoneC, zoneD;
  logic [39:0] expCD;

  int compared   = 0;
  int mismatched = 0;

  collision_arbiter dutA (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballReq(reqA),
    .ballOffsetX(offX), .ballOffsetY(offY), .batReq(batReq), .batOffsetX(batOffsetX),
    .brikReq(brikReq), .ballCollision(collA), .batZone(zoneA), .brikCollision(brikA),
    .frameBrickHits(hitsA), .score(scoreA));

  collision_arbiter #(.COOLDOWN_FRAMES(2)) dutB (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballReq(reqB),
    .ballOffsetX(offX), .ballOffsetY(offY), .batReq(batReq), .batOffsetX(batOffsetX),
    .brikReq(brikReq), .ballCollision(collB), .batZone(zoneB), .brikCollision(brikB),
    .frameBrickHits(hitsB), .score(scoreB));

  collision_arbiter #(.NUM_BALLS(8)) dutC (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballReq(reqCD),
    .ballOffsetX(offX8), .ballOffsetY(offY8), .batReq(batReq), .batOffsetX(batOffsetX),
    .brikReq(brikReq), .ballCollision(collC), .batZone(zoneC), .brikCollision(brikC),
    .frameBrickHits(hitsC), .score(scoreC));

  collision_arbiter #(.NUM_BALLS(8), .CNT_W(2)) dutD (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballReq(reqCD),
    .ballOffsetX(offX8), .ballOffsetY(offY8), .batReq(batReq), .batOffsetX(batOffsetX),
    .brikReq(brikReq), .ballCollision(collD), .batZone(zoneD), .brikCollision(brikD),
    .frameBrickHits(hitsD), .score(scoreD));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the DUTs sample them, then return to idle.
  task automatic applyStimulus(input logic sof, input logic [1:0] ra, input logic [1:0] rb,
                               input logic [7:0] rcd, input logic bat, input logic [10:0] bx,
                               input logic brik, input logic [10:0] ox0, input logic [10:0] oy0,
                               input logic [10:0] ox1, input logic [10:0] oy1);
    startOfFrame = sof;
    reqA         = ra;
    reqB         = rb;
    reqCD        = rcd;
    batReq       = bat;
    batOffsetX   = bx;
    brikReq      = brik;
    offX         = {ox1, ox0};
    offY         = {oy1, oy0};
    tick();
    startOfFrame = 1'b0;
    reqA         = 2'b00;
    reqB         = 2'b00;
    reqCD        = 8'h00;
    batReq       = 1'b0;
    brikReq      = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 11'd0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
  endtask

  task automatic frameStart();
    applyStimulus(1'b1, 2'b00, 2'b00, 8'h00, 1'b0, 11'd0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    batReq       = 1'b0;
    brikReq      = 1'b0;
    batOffsetX   = 11'd0;
    reqA         = 2'b00;
    reqB         = 2'b00;
    reqCD        = 8'h00;
    offX         = '0;
    offY         = '0;
    for (int k = 0; k < 8; k++) begin
      offX8[k*11 +: 11] = 11'd4;
      offY8[k*11 +: 11] = 11'd5;
    end
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_coll",  64'(collA),  64'd0);
    checkOutput("rst_zone",  64'(zoneA),  64'd0);
    checkOutput("rst_brik",  64'(brikA),  64'd0);
    checkOutput("rst_hits",  64'(hitsA),  64'd0);
    checkOutput("rst_score", 64'(scoreA), 64'd0);

    $display("[TB] bat top hit, then repeat in same frame");
    applyStimulus(1'b0, 2'b01, 2'b00, 8'h00, 1'b1, 11'd20, 1'b0, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("bat_top_code", 64'(collA[4:0]), 64'(TOP));
    checkOutput("bat_top_zone", 64'(zoneA[2:0]), 64'd3);
    checkOutput("bat_top_b1",   64'(collA[9:5]), 64'd0);
    checkOutput("bat_top_brik", 64'(brikA),      64'd0);
    applyStimulus(1'b0, 2'b01, 2'b00, 8'h00, 1'b1, 11'd20, 1'b0, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("repeat_coll", 64'(collA), 64'd0);
    checkOutput("repeat_zone", 64'(zoneA), 64'd0);

    $display("[TB] brick side hits coincident with frame start");
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("right_code",  64'(collA[4:0]), 64'(RIGHT));
    checkOutput("right_brik",  64'(brikA),      64'd1);
    checkOutput("right_zone",  64'(zoneA),      64'd0);
    checkOutput("right_score", 64'(scoreA),     64'd10);
    checkOutput("right_hits",  64'(hitsA),      64'd1);
    idle();
    checkOutput("pulse_brik", 64'(brikA), 64'd0);
    checkOutput("pulse_coll", 64'(collA), 64'd0);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b0, 11'd0, 1'b1, 11'd9, 11'd5, 11'd0, 11'd0);
    checkOutput("left_code",  64'(collA[4:0]), 64'(LEFT));
    checkOutput("left_score", 64'(scoreA),     64'd20);

    $display("[TB] bat zones and bottom band");
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b1, 11'd60, 1'b0, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("zone60_code", 64'(collA[4:0]), 64'(TOP));
    checkOutput("zone60",      64'(zoneA[2:0]), 64'd7);
    checkOutput("zone60_hits", 64'(hitsA),      64'd0);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b1, 11'd55, 1'b0, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("zone55", 64'(zoneA[2:0]), 64'd7);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b1, 11'd0, 1'b0, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("zone0", 64'(zoneA[2:0]), 64'd1);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b1, 11'd20, 1'b0, 11'd3, 11'd1, 11'd0, 11'd0);
    checkOutput("bottom_code", 64'(collA[4:0]), 64'(BOTTOM));
    checkOutput("bottom_zone", 64'(zoneA),      64'd0);

    $display("[TB] two balls on a brick in one cycle");
    applyStimulus(1'b1, 2'b11, 2'b00, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd9, 11'd7);
    checkOutput("dual_coll",  64'(collA),  64'({LEFT, RIGHT}));
    checkOutput("dual_brik",  64'(brikA),  64'd1);
    checkOutput("dual_score", 64'(scoreA), 64'd30);
    checkOutput("dual_hits",  64'(hitsA),  64'd1);
    applyStimulus(1'b1, 2'b01, 2'b00, 8'h00, 1'b0, 11'd20, 1'b1, 11'd3, 11'd12, 11'd0, 11'd0);
    checkOutput("brik_top_code", 64'(collA[4:0]), 64'(TOP));
    checkOutput("brik_top_zone", 64'(zoneA),      64'd0);

    $display("[TB] cooldown of two frames");
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_first", 64'(collB[4:0]), 64'(RIGHT));
    frameStart();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_frame1", 64'(collB), 64'd0);
    frameStart();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_frame2", 64'(collB), 64'd0);
    frameStart();
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_frame3", 64'(collB[4:0]), 64'(RIGHT));
    frameStart();
    frameStart();
    applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_sof_hit", 64'(collB[4:0]), 64'(RIGHT));
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_after_sof", 64'(collB), 64'd0);
    applyStimulus(1'b1, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("cd_next_sof", 64'(collB), 64'd0);
    checkOutput("cd_score",    64'(scoreB), 64'd30);

    $display("[TB] reset during cooldown");
    reset = 1'b1;
    #1;
    checkOutput("midrst_scoreB", 64'(scoreB), 64'd0);
    checkOutput("midrst_scoreA", 64'(scoreA), 64'd0);
    checkOutput("midrst_hitsA",  64'(hitsA),  64'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 2'b01, 8'h00, 1'b0, 11'd0, 1'b1, 11'd4, 11'd5, 11'd0, 11'd0);
    checkOutput("postrst_coll",  64'(collB[4:0]), 64'(RIGHT));
    checkOutput("postrst_score", 64'(scoreB),     64'd10);

    $display("[TB] frame tallies and saturation");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 8'(1 << k), 1'b0, 11'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0);
      checkOutput("tally_brik", 64'(brikC), 64'd1);
    end
    checkOutput("tally_scoreC", 64'(scoreC), 64'd50);
    checkOutput("tally_scoreD", 64'(scoreD), 64'd50);
    frameStart();
    checkOutput("tally_hitsC", 64'(hitsC), 64'd5);
    checkOutput("sat_hitsD",   64'(hitsD), 64'd3);
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h01, 1'b0, 11'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0);
    checkOutput("c_ball0", 64'(collC), 64'(RIGHT));
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h0C, 1'b0, 11'd0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0);
    expCD = '0;
    expCD[14:10] = RIGHT;
    expCD[19:15] = RIGHT;
    checkOutput("c_dual_coll",  64'(collC),  64'(expCD));
    checkOutput("d_dual_brik",  64'(brikD),  64'd1);
    checkOutput("d_dual_score", 64'(scoreD), 64'd70);
    frameStart();
    checkOutput("frame2_hitsC", 64'(hitsC), 64'd2);
    checkOutput("frame2_hitsD", 64'(hitsD), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
